// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Opcode constants, fetch-state encoding and fetch defaults
//                shared by the single-cycle MIPS front end.
//  Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    // Branch displacement: sign-extended word offset turned into a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_logic
//  Description : Combinational next-PC selection (jump > taken branch > +4).
//  Revision    : 1.0
// ============================================================================
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_unused_op;

    // The opcode field plays no part in target arithmetic.
    assign w_unused_op     = &{1'b0, instr[31:26]};
    assign w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign w_branch_target = pc_plus4 + branch_offset(instr[15:0]);

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = w_jump_target;
        end else if (Branch && Zero) begin
            next_pc = w_branch_target;
        end
    end

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch / PC sequencing front end with a
//                valid/ready hold toward the datapath.
//  Revision    : 1.0
// ============================================================================
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_valid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [5:0]         Op,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               Zero,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [COUNT_W-1:0] issue_count
);

    localparam logic [31:0] C_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [COUNT_W-1:0] r_issue_count;
    logic [31:0]        w_next_pc;
    logic               w_req;
    logic               w_valid;
    logic               w_capture;
    logic               w_accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:   if (imem_valid)  w_state_next = ISSUE;
            ISSUE:   if (instr_ready) w_state_next = FETCH;
            default: w_state_next = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            // The request is masked while reset is held so nothing is
            // requested during the reset cycle itself.
            FETCH:   w_req   = ~reset;
            ISSUE:   w_valid = 1'b1;
            default: begin
                w_req   = 1'b0;
                w_valid = 1'b0;
            end
        endcase
    end

    assign w_capture = (r_state == FETCH) && imem_valid;
    assign w_accept  = w_valid && instr_ready;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= C_RESET_PC_ALIGNED;
            r_instr       <= 32'h0000_0000;
            r_issue_count <= '0;
        end else begin
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_pc          <= w_next_pc;
                r_issue_count <= r_issue_count + COUNT_W'(1);
            end
        end
    end

    next_pc_logic u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (r_instr),
        .Branch   (Branch),
        .Jump     (Jump),
        .Zero     (Zero),
        .next_pc  (w_next_pc)
    );

    assign imem_req    = w_req;
    assign imem_addr   = {r_pc[31:2], 2'b00};
    assign instr       = r_instr;
    assign Op          = r_instr[31:26];
    assign instr_valid = w_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign issue_count = r_issue_count;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Revision    : 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        Branch;
    logic        Jump;
    logic        Zero;

    logic        imem_req,   h_imem_req;
    logic [31:0] imem_addr,  h_imem_addr;
    logic [31:0] instr,      h_instr;
    logic [5:0]  Op,         h_Op;
    logic        instr_valid, h_instr_valid;
    logic [31:0] pc,         h_pc;
    logic [31:0] pc_plus4,   h_pc_plus4;
    logic [31:0] issue_count, h_issue_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(instr), .Op(Op), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .pc(pc), .pc_plus4(pc_plus4), .issue_count(issue_count)
    );

    // Same stimulus, different reset PC, to reach a high-region jump.
    fetch_sequencer #(.RESET_PC(32'h1000_0010), .COUNT_W(32)) u_dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(h_imem_req), .imem_addr(h_imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(h_instr), .Op(h_Op), .instr_valid(h_instr_valid),
        .instr_ready(instr_ready), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .pc(h_pc), .pc_plus4(h_pc_plus4), .issue_count(h_issue_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] word);
        imem_valid = 1'b1; imem_rdata = word;
        step();
        imem_valid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic accept(input logic b, input logic j, input logic z);
        instr_ready = 1'b1; Branch = b; Jump = j; Zero = z;
        step();
        instr_ready = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        step(); step();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_low got=%b exp=0", imem_req); end
        reset = 1'b0; #1;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (issue_count !== 32'h0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", issue_count); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL post_reset_req got=%b exp=1", imem_req); end
        n_cmp++; if (h_pc !== 32'h1000_0010) begin n_err++; $display("FAIL reset_pc_hi got=%h exp=10000010", h_pc); end
    endtask

    task automatic test_zero_wait_lw();
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL lw_addr got=%h exp=00000000", imem_addr); end
        deliver(32'h8C08_0004);
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid got=%b exp=1", instr_valid); end
        n_cmp++; if (Op !== 6'h23) begin n_err++; $display("FAIL lw_op got=%h exp=23", Op); end
        n_cmp++; if (instr !== 32'h8C08_0004) begin n_err++; $display("FAIL lw_instr got=%h exp=8c080004", instr); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL lw_issue_req got=%b exp=0", imem_req); end
        accept(1'b0, 1'b0, 1'b0);
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL lw_next_pc got=%h exp=00000004", pc); end
        n_cmp++; if (issue_count !== 32'd1) begin n_err++; $display("FAIL lw_count got=%0d exp=1", issue_count); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL lw_valid_drop got=%b exp=0", instr_valid); end
        n_cmp++; if (pc_plus4 !== 32'h8) begin n_err++; $display("FAIL lw_pc_plus4 got=%h exp=00000008", pc_plus4); end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL wait_cycle%0d req=%b addr=%h valid=%b exp req=1 addr=00000004 valid=0",
                                  i, imem_req, imem_addr, instr_valid);
            end
            step();
        end
        deliver(32'h0000_0000);
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid got=%b exp=1", instr_valid); end
        accept(1'b0, 1'b0, 1'b0);
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL wait_next_pc got=%h exp=00000008", pc); end
    endtask

    task automatic test_branch();
        deliver(32'h1000_FFFE);
        n_cmp++; if (Op !== 6'h04) begin n_err++; $display("FAIL beq_op got=%h exp=04", Op); end
        accept(1'b1, 1'b0, 1'b1);
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL beq_taken got=%h exp=00000004", pc); end
        deliver(32'h0000_0000);
        accept(1'b0, 1'b0, 1'b0);
        deliver(32'h1000_FFFE);
        accept(1'b1, 1'b0, 1'b0);
        n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL beq_not_taken got=%h exp=0000000c", pc); end
        n_cmp++; if (issue_count !== 32'd5) begin n_err++; $display("FAIL beq_count got=%0d exp=5", issue_count); end
    endtask

    task automatic test_jump();
        do_reset();
        deliver(32'h0800_0040);
        n_cmp++; if (h_pc !== 32'h1000_0010) begin n_err++; $display("FAIL j_pc_before got=%h exp=10000010", h_pc); end
        accept(1'b1, 1'b1, 1'b1);
        n_cmp++; if (h_pc !== 32'h1000_0100) begin n_err++; $display("FAIL j_priority_hi got=%h exp=10000100", h_pc); end
        n_cmp++; if (pc !== 32'h0000_0100) begin n_err++; $display("FAIL j_priority_lo got=%h exp=00000100", pc); end
    endtask

    task automatic test_stall();
        deliver(32'h012A_4020);
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
            n_cmp++; if (instr !== 32'h012A_4020 || Op !== 6'h00 || pc !== 32'h100 ||
                         imem_req !== 1'b0 || issue_count !== 32'd1 || instr_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_cycle%0d instr=%h op=%h pc=%h req=%b cnt=%0d valid=%b exp 012a4020/00/00000100/0/1/1",
                                  i, instr, Op, pc, imem_req, issue_count, instr_valid);
            end
            step();
        end
        imem_valid = 1'b0;
        accept(1'b0, 1'b0, 1'b0);
        n_cmp++; if (pc !== 32'h104 || issue_count !== 32'd2) begin
            n_err++; $display("FAIL stall_release pc=%h cnt=%0d exp pc=00000104 cnt=2", pc, issue_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        deliver(32'h1000_FFFE);
        accept(1'b1, 1'b0, 1'b1);
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL neg_branch got=%h exp=fffffffc", pc); end
        n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
        deliver(32'h0000_0000);
        accept(1'b0, 1'b0, 1'b0);
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=00000000", pc); end
    endtask

    task automatic test_reset_midflight();
        deliver(32'h8C08_0004);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (pc !== 32'h0 || instr_valid !== 1'b0 || issue_count !== 32'd0 || instr !== 32'h0) begin
            n_err++; $display("FAIL reset_in_issue pc=%h valid=%b cnt=%0d instr=%h exp 0/0/0/0",
                              pc, instr_valid, issue_count, instr);
        end
        deliver(32'h0000_0000);
        accept(1'b0, 1'b0, 1'b0);
        reset = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h8C08_0004;
        step();
        reset = 1'b0; imem_valid = 1'b0;
        n_cmp++; if (pc !== 32'h0 || instr_valid !== 1'b0 || issue_count !== 32'd0) begin
            n_err++; $display("FAIL reset_in_fetch pc=%h valid=%b cnt=%0d exp 0/0/0", pc, instr_valid, issue_count);
        end
        step();
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL late_resp_dropped valid=%b instr=%h req=%b exp 0/00000000/1",
                              instr_valid, instr, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_lw();
        test_latency();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
